// File: rtl/fp_addsub_pipe.sv
// fp_addsub_pipe: 3-stage float add/sub (align, add, normalise/round); `FPA_ROUND_EN selects round-to-nearest-even, else truncate.
// Latency 3, one result/cycle; bubble-collapsing valid/ready, result held under stall, fills 3 deep before in_ready drops.
module fp_addsub_pipe #(
  parameter int EXP_W = 5,
  parameter int MAN_W = 10
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [EXP_W+MAN_W:0] a,
  input  logic [EXP_W+MAN_W:0] b,
  input  logic                 sub,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [EXP_W+MAN_W:0] result,
  output logic [2:0]           flags
);
  localparam int W     = 1 + EXP_W + MAN_W;
  localparam int SIG_W = MAN_W + 4;
  localparam int SUM_W = MAN_W + 5;
  localparam int LZ_W  = $clog2(SIG_W + 1);
  localparam int EW    = EXP_W + LZ_W + 1;
  localparam logic [EXP_W-1:0] EMAX = {EXP_W{1'b1}};
  localparam logic [W-1:0] QNAN = {1'b0, EMAX, 1'b1, {(MAN_W-1){1'b0}}};
`ifdef FPA_ROUND_EN
  localparam bit RND_EN = 1'b1;
`else
  localparam bit RND_EN = 1'b0;
`endif

  function automatic logic [LZ_W-1:0] lzc(input logic [SIG_W-1:0] v);
    lzc = LZ_W'(SIG_W);
    for (int i = 0; i < SIG_W; i++)
      if (v[i]) lzc = LZ_W'(SIG_W - 1 - i);
  endfunction

  logic v1, v2, v3, ld1, ld2, ld3;

  assign ld3       = v2 && (!v3 || out_ready);
  assign ld2       = v1 && (!v2 || ld3);
  assign in_ready  = !v1 || ld2;
  assign ld1       = in_valid && in_ready;
  assign out_valid = v3;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      v1 <= 1'b0;
      v2 <= 1'b0;
      v3 <= 1'b0;
    end else begin
      v1 <= ld1 || (v1 && !ld2);
      v2 <= ld2 || (v2 && !ld3);
      v3 <= ld3 || (v3 && !out_ready);
    end
  end

  // Stage 1: classify, swap so X has the larger magnitude, align Y
  logic             sa, sb, a_zero, b_zero, a_nan, b_nan, a_inf, b_inf, a_big;
  logic [EXP_W-1:0] ea, eb, ex, ey, d;
  logic [MAN_W-1:0] ma, mb, mx, my;
  logic [SIG_W-1:0] sig_y, y_al;
  logic             spec;
  logic [W-1:0]     spec_res;
  logic [2:0]       spec_flg;

  assign sa     = a[W-1];
  assign sb     = b[W-1] ^ sub;
  assign ea     = a[W-2:MAN_W];
  assign eb     = b[W-2:MAN_W];
  assign a_zero = (ea == '0);
  assign b_zero = (eb == '0);
  assign ma     = a_zero ? '0 : a[MAN_W-1:0];
  assign mb     = b_zero ? '0 : b[MAN_W-1:0];
  assign a_nan  = (ea == EMAX) && (ma != '0);
  assign b_nan  = (eb == EMAX) && (mb != '0);
  assign a_inf  = (ea == EMAX) && (ma == '0);
  assign b_inf  = (eb == EMAX) && (mb == '0);
  assign a_big  = {ea, ma} >= {eb, mb};
  assign ex     = a_big ? ea : eb;
  assign ey     = a_big ? eb : ea;
  assign mx     = a_big ? ma : mb;
  assign my     = a_big ? mb : ma;
  assign d      = ex - ey;
  assign sig_y  = {1'b1, my, 3'b000};

  always_comb begin
    y_al = '0;
    if (32'(d) >= MAN_W + 3)
      y_al = SIG_W'(1);
    else
      y_al = (sig_y >> d) | SIG_W'(|(sig_y & ~({SIG_W{1'b1}} << d)));
  end

  always_comb begin
    spec     = 1'b1;
    spec_res = '0;
    spec_flg = '0;
    if (a_nan || b_nan) begin
      spec_res = QNAN;
    end else if (a_inf && b_inf && (sa != sb)) begin
      spec_res = QNAN;
      spec_flg = 3'b100;
    end else if (a_inf) begin
      spec_res = {sa, EMAX, {MAN_W{1'b0}}};
    end else if (b_inf) begin
      spec_res = {sb, EMAX, {MAN_W{1'b0}}};
    end else if (a_zero && b_zero) begin
      spec_res = {sa & sb, {(W-1){1'b0}}};
    end else if (a_zero) begin
      spec_res = {sb, eb, mb};
    end else if (b_zero) begin
      spec_res = {sa, ea, ma};
    end else begin
      spec = 1'b0;
    end
  end

  logic             s1_sign, s1_add, s1_spec;
  logic [EXP_W-1:0] s1_exp;
  logic [SIG_W-1:0] s1_x, s1_y;
  logic [W-1:0]     s1_spec_res;
  logic [2:0]       s1_spec_flg;

  always_ff @(posedge clk) begin
    if (ld1) begin
      s1_sign     <= a_big ? sa : sb;
      s1_add      <= (sa == sb);
      s1_exp      <= ex;
      s1_x        <= {1'b1, mx, 3'b000};
      s1_y        <= y_al;
      s1_spec     <= spec;
      s1_spec_res <= spec_res;
      s1_spec_flg <= spec_flg;
    end
  end

  // Stage 2: magnitude add or subtract; X >= Y so the difference is never negative
  logic             s2_sign, s2_spec;
  logic [EXP_W-1:0] s2_exp;
  logic [SUM_W-1:0] s2_sum;
  logic [W-1:0]     s2_spec_res;
  logic [2:0]       s2_spec_flg;

  always_ff @(posedge clk) begin
    if (ld2) begin
      s2_sign     <= s1_sign;
      s2_exp      <= s1_exp;
      s2_sum      <= s1_add ? ({1'b0, s1_x} + {1'b0, s1_y}) : ({1'b0, s1_x} - {1'b0, s1_y});
      s2_spec     <= s1_spec;
      s2_spec_res <= s1_spec_res;
      s2_spec_flg <= s1_spec_flg;
    end
  end

  // Stage 3: normalise, round, range check
  logic [LZ_W-1:0]  lz;
  logic [SIG_W-1:0] norm;
  logic [EW-1:0]    e_n, e_r;
  logic             rinc, rcarry;
  logic [MAN_W+1:0] mant_r;
  logic [MAN_W-1:0] man_o;
  logic [W-1:0]     res_d;
  logic [2:0]       flg_d;

  assign lz = lzc(s2_sum[SIG_W-1:0]);

  always_comb begin
    norm = '0;
    e_n  = '0;
    if (s2_sum[SUM_W-1]) begin
      norm = {s2_sum[SUM_W-1:2], s2_sum[1] | s2_sum[0]};
      e_n  = EW'(s2_exp) + EW'(1);
    end else begin
      norm = s2_sum[SIG_W-1:0] << lz;
      e_n  = EW'(s2_exp) - EW'(lz);
    end
    rinc   = RND_EN & norm[2] & (norm[1] | norm[0] | norm[3]);
    mant_r = {1'b0, norm[SIG_W-1:3]} + (MAN_W+2)'(rinc);
    rcarry = mant_r[MAN_W+1];
    e_r    = e_n + EW'(rcarry);
    man_o  = rcarry ? mant_r[MAN_W:1] : mant_r[MAN_W-1:0];
  end

  // e_r is two's complement, so its MSB flags an exponent pushed below zero
  always_comb begin
    res_d = '0;
    flg_d = '0;
    if (s2_spec) begin
      res_d = s2_spec_res;
      flg_d = s2_spec_flg;
    end else if (s2_sum == '0) begin
      res_d = '0;
    end else if (e_r[EW-1] || (e_r == '0)) begin
      res_d = {s2_sign, {(W-1){1'b0}}};
      flg_d = 3'b001;
    end else if (e_r >= EW'(EMAX)) begin
      res_d = {s2_sign, EMAX, {MAN_W{1'b0}}};
      flg_d = 3'b010;
    end else begin
      res_d = {s2_sign, e_r[EXP_W-1:0], man_o};
    end
  end

  logic [W-1:0] s3_res;
  logic [2:0]   s3_flg;

  always_ff @(posedge clk) begin
    if (ld3) begin
      s3_res <= res_d;
      s3_flg <= flg_d;
    end
  end

  assign result = v3 ? s3_res : '0;
  assign flags  = v3 ? s3_flg : '0;
endmodule
